// File: rtl/exc_issue_ctrl.sv
// exc_issue_ctrl: execute-stage trap/eret requester toward CP0.
// Issues one request per event, flushes younger stages, redirects fetch.
module exc_issue_ctrl #(
   parameter logic [31:0] VECTOR       = 32'h00400004,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [3:0]  CAUSE_SYS    = 4'b1000,
   parameter logic [3:0]  CAUSE_BRK    = 4'b1001,
   parameter logic [3:0]  CAUSE_TEQ    = 4'b1101
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_syscall,
   input  logic        ex_break,
   input  logic        ex_teq,
   input  logic        ex_eq,
   input  logic        ex_eret,
   input  logic        stall_in,
   input  logic [31:0] status,
   input  logic [31:0] epc,
   output logic        exception,
   output logic        eret,
   output logic [3:0]  cause,
   output logic [31:0] exc_pc,
   output logic        flush,
   output logic        pc_redirect,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      FLUSH,
      REDIRECT
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  cnt_q;
   logic [3:0]  cnt_d;
   logic        kind_eret_q;
   logic [3:0]  cause_q;
   logic [31:0] exc_pc_q;
   logic [31:0] redir_q;

   logic        hit_eret;
   logic        hit_sys;
   logic        hit_brk;
   logic        hit_teq;
   logic        take;
   logic        take_eret;
   logic [3:0]  take_cause;

   // Mask events with status and pick one by priority eret > sys > brk > teq.
   always_comb begin
      hit_eret   = ex_eret;
      hit_sys    = ex_syscall & status[0] & status[1];
      hit_brk    = ex_break & status[0] & status[2];
      hit_teq    = ex_teq & ex_eq & status[0] & status[3];
      take       = ex_valid & ~stall_in &
                   (hit_eret | hit_sys | hit_brk | hit_teq);
      take_eret  = 1'b0;
      take_cause = 4'd0;
      if (hit_eret) begin
         take_eret = 1'b1;
      end else if (hit_sys) begin
         take_cause = CAUSE_SYS;
      end else if (hit_brk) begin
         take_cause = CAUSE_BRK;
      end else if (hit_teq) begin
         take_cause = CAUSE_TEQ;
      end
   end

   // State and flush counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Sequence: one request cycle, counted flush, one redirect cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (take) state_d = ISSUE;
         end
         ISSUE: begin
            state_d = FLUSH;
            cnt_d   = CNT_LOAD;
         end
         FLUSH: begin
            if (cnt_q == 4'd0) state_d = REDIRECT;
            else               cnt_d   = cnt_q - 4'd1;
         end
         REDIRECT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Capture the accepted event; younger instructions are ignored after.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kind_eret_q <= 1'b0;
         cause_q     <= 4'd0;
         exc_pc_q    <= 32'd0;
      end else if (state_q == IDLE && take) begin
         kind_eret_q <= take_eret;
         cause_q     <= take_cause;
         exc_pc_q    <= ex_pc;
      end
   end

   // Return target: EPC is read while CP0 sees the eret request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redir_q <= 32'd0;
      end else if (state_q == ISSUE) begin
         redir_q <= kind_eret_q ? epc : VECTOR;
      end
   end

   assign exception   = (state_q == ISSUE) & ~kind_eret_q;
   assign eret        = (state_q == ISSUE) & kind_eret_q;
   assign cause       = exception ? cause_q : 4'd0;
   assign exc_pc      = exc_pc_q;
   assign flush       = (state_q != IDLE);
   assign busy        = (state_q != IDLE);
   assign pc_redirect = (state_q == REDIRECT);
   assign redirect_pc = redir_q;

endmodule
